// File: rtl/amo_bank_arbiter.sv
// amo_bank_arbiter: round-robin arbiter in front of a single memory bank that
// serialises atomic operations. The search for the selected master starts at
// the priority pointer. After a granted AMO the arbiter spends one blocking
// cycle (AmoBusy) so the shim can finish its read-modify-write. Every
// handshake produces a response exactly one cycle later.
module amo_bank_arbiter #(
  parameter int NumIn        = 4,
  parameter int AddrMemWidth = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumIn-1:0]                     req_i,
  output logic [NumIn-1:0]                     gnt_o,
  input  logic [NumIn-1:0][AddrMemWidth-1:0]   add_i,
  input  logic [NumIn-1:0][3:0]                amo_i,
  input  logic [NumIn-1:0]                     wen_i,
  input  logic [NumIn-1:0][63:0]               wdata_i,
  input  logic [NumIn-1:0][7:0]                be_i,
  output logic [63:0]                          rdata_o,
  output logic [NumIn-1:0]                     rvalid_o,
  output logic                                 bank_req_o,
  input  logic                                 bank_gnt_i,
  output logic [AddrMemWidth-1:0]              bank_add_o,
  output logic [3:0]                           bank_amo_o,
  output logic                                 bank_wen_o,
  output logic [63:0]                          bank_wdata_o,
  output logic [7:0]                           bank_be_o,
  input  logic [63:0]                          bank_rdata_i
);

  localparam int PtrW = (NumIn > 1) ? $clog2(NumIn) : 1;

  typedef enum logic {
    Ready   = 1'b0,
    AmoBusy = 1'b1
  } state_e;

  state_e          r_state;
  state_e          w_stateNext;
  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] r_rspId;
  logic            r_rspValid;
  logic [PtrW-1:0] w_sel;
  logic [PtrW-1:0] w_ptrNext;
  logic            w_found;
  logic            w_handshake;

  // Round-robin search: the first requester at or after the pointer, wrapping modulo NumIn
  always_comb begin
    logic [PtrW:0] idx;
    idx     = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NumIn; i++) begin
      idx = {1'b0, r_ptr} + (PtrW+1)'(i);
      if (idx >= (PtrW+1)'(NumIn)) begin
        idx = idx - (PtrW+1)'(NumIn);
      end
      if (!w_found && req_i[idx[PtrW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = idx[PtrW-1:0];
      end
    end
  end

  // Pointer moves one past the master that just won, wrapping at NumIn
  always_comb begin
    w_ptrNext = '0;
    if (w_sel != PtrW'(NumIn - 1)) begin
      w_ptrNext = w_sel + PtrW'(1);
    end
  end

  // FSM next state plus the bank request/grant outputs; AmoBusy blocks the bank for one cycle
  always_comb begin
    w_stateNext  = r_state;
    w_handshake  = 1'b0;
    gnt_o        = '0;
    bank_req_o   = 1'b0;
    bank_amo_o   = '0;
    bank_add_o   = add_i[w_sel];
    bank_wen_o   = wen_i[w_sel];
    bank_wdata_o = wdata_i[w_sel];
    bank_be_o    = be_i[w_sel];
    case (r_state)
      Ready: begin
        if (w_found) begin
          bank_req_o   = 1'b1;
          bank_amo_o   = amo_i[w_sel];
          gnt_o[w_sel] = bank_gnt_i;
          w_handshake  = bank_gnt_i;
          if (bank_gnt_i && (amo_i[w_sel] != 4'd0)) begin
            w_stateNext = AmoBusy;
          end
        end
      end
      AmoBusy: begin
        w_stateNext = Ready;
      end
      default: begin
        w_stateNext = Ready;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= Ready;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Priority pointer and response tracking; a response always follows its handshake by one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_rspId    <= '0;
      r_rspValid <= 1'b0;
    end else begin
      r_rspValid <= w_handshake;
      if (w_handshake) begin
        r_ptr   <= w_ptrNext;
        r_rspId <= w_sel;
      end
    end
  end

  // Response steering: shim read data goes straight out and the valid goes to the recorded master
  always_comb begin
    rvalid_o          = '0;
    rvalid_o[r_rspId] = r_rspValid;
    rdata_o           = bank_rdata_i;
  end

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// tb_amo_bank_arbiter: directed vector table plus randomized traffic checked
// against a behavioural model of the arbiter and of the memory shim.
module tb_amo_bank_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [N-1:0]           req_i;
  logic [N-1:0]           gnt_o;
  logic [N-1:0][AW-1:0]   add_i;
  logic [N-1:0][3:0]      amo_i;
  logic [N-1:0]           wen_i;
  logic [N-1:0][63:0]     wdata_i;
  logic [N-1:0][7:0]      be_i;
  logic [63:0]            rdata_o;
  logic [N-1:0]           rvalid_o;
  logic                   bank_req_o;
  logic                   bank_gnt_i;
  logic [AW-1:0]          bank_add_o;
  logic [3:0]             bank_amo_o;
  logic                   bank_wen_o;
  logic [63:0]            bank_wdata_o;
  logic [7:0]             bank_be_o;
  logic [63:0]            bank_rdata_i;

  amo_bank_arbiter #(.NumIn(N), .AddrMemWidth(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .amo_i(amo_i), .wen_i(wen_i), .wdata_i(wdata_i),
    .be_i(be_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .bank_req_o(bank_req_o), .bank_gnt_i(bank_gnt_i),
    .bank_add_o(bank_add_o), .bank_amo_o(bank_amo_o),
    .bank_wen_o(bank_wen_o), .bank_wdata_o(bank_wdata_o),
    .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] amoMask;
    logic         gnt;
    logic [N-1:0] expGnt;
    logic         expBankReq;
    logic [N-1:0] expRvalid;
  } vec_t;

  vec_t          tbl[16];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] shimAddr;

  // Behavioural model state
  int            mPtr;
  bit            mBusy;
  bit            mRspValid;
  int            mRspId;
  logic [AW-1:0] mRspAddr;

  function automatic logic [63:0] memData(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  function automatic logic [AW-1:0] tblAddr(input int m);
    return 32'h0000_1000 + AW'(m * 16);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] amoMask, input logic gnt);
    req_i = req;
    for (int m = 0; m < N; m++) begin
      amo_i[m]   = amoMask[m] ? 4'd2 : 4'd0;
      add_i[m]   = tblAddr(m);
      wen_i[m]   = 1'b0;
      wdata_i[m] = 64'(m);
      be_i[m]    = 8'hFF;
    end
    bank_gnt_i   = gnt;
    bank_rdata_i = memData(shimAddr);
  endtask

  task automatic shimCapture();
    if (bank_req_o && bank_gnt_i) shimAddr = bank_add_o;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    shimAddr = '0;
    rst_ni   = 1'b0;
    applyStimulus('0, '0, 1'b0);
    #1;
    checkOutput("rst_rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("rst_bankreq", 64'(bank_req_o), 64'd0);
    checkOutput("rst_gnt", 64'(gnt_o), 64'd0);
    applyStimulus(4'b0001, '0, 1'b1);
    #1;
    checkOutput("rst_comb_gnt", 64'(gnt_o), 64'd1);
    checkOutput("rst_comb_rvalid", 64'(rvalid_o), 64'd0);
    applyStimulus('0, '0, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;

    tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0000};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b0100};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1000};
    tbl[5]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000};
    tbl[6]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000};
    tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000};
    tbl[8]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0000};
    tbl[9]  = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0010};
    tbl[10] = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100};
    tbl[11] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0000};
    tbl[12] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0001};
    tbl[13] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b0100};
    tbl[14] = '{4'b1001, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b1000};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].req, tbl[i].amoMask, tbl[i].gnt);
      #1;
      checkOutput($sformatf("v%0d_gnt", i), 64'(gnt_o), 64'(tbl[i].expGnt));
      checkOutput($sformatf("v%0d_bankreq", i), 64'(bank_req_o), 64'(tbl[i].expBankReq));
      checkOutput($sformatf("v%0d_rvalid", i), 64'(rvalid_o), 64'(tbl[i].expRvalid));
      for (int m = 0; m < N; m++) begin
        if (tbl[i].expRvalid[m]) checkOutput($sformatf("v%0d_rdata", i), rdata_o, memData(tblAddr(m)));
      end
      shimCapture();
      tick();
    end

    // Reset while AmoBusy: the pending AMO response must vanish and the pointer restart at 0
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    #1;
    checkOutput("rb_amo_gnt", 64'(gnt_o), 64'b0100);
    checkOutput("rb_amo_op", 64'(bank_amo_o), 64'd2);
    shimCapture();
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #1;
    checkOutput("rb_busy_rvalid", 64'(rvalid_o), 64'b0100);
    checkOutput("rb_busy_bankreq", 64'(bank_req_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    checkOutput("rb_rst_rvalid", 64'(rvalid_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    #1;
    checkOutput("rb_post_rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("rb_post_bankreq", 64'(bank_req_o), 64'd1);
    checkOutput("rb_post_gnt0", 64'(gnt_o), 64'd0);
    tick();
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    #1;
    checkOutput("rb_post_gnt", 64'(gnt_o), 64'b0001);
    checkOutput("rb_post_rvalid2", 64'(rvalid_o), 64'd0);
    tick();

    // Randomized traffic against the behavioural model
    rst_ni = 1'b0;
    applyStimulus('0, '0, 1'b0);
    tick();
    rst_ni    = 1'b1;
    mPtr      = 0;
    mBusy     = 0;
    mRspValid = 0;
    mRspId    = 0;
    mRspAddr  = '0;
    for (int c = 0; c < 400; c++) begin
      bit           expReq;
      bit           hs;
      int           sel;
      logic [N-1:0] expGnt;
      logic [N-1:0] expRvalid;
      req_i = N'($urandom);
      for (int m = 0; m < N; m++) begin
        amo_i[m]   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        add_i[m]   = AW'($urandom);
        wen_i[m]   = 1'($urandom);
        wdata_i[m] = {$urandom, $urandom};
        be_i[m]    = 8'($urandom);
      end
      bank_gnt_i   = ($urandom_range(0, 3) != 0);
      bank_rdata_i = memData(shimAddr);
      #1;
      sel = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (req_i[(mPtr + k) % N]) sel = (mPtr + k) % N;
      end
      expReq    = !mBusy && (req_i != '0);
      expGnt    = (expReq && bank_gnt_i) ? (N'(1) << sel) : '0;
      expRvalid = mRspValid ? (N'(1) << mRspId) : '0;
      checkOutput("rnd_gnt", 64'(gnt_o), 64'(expGnt));
      checkOutput("rnd_bankreq", 64'(bank_req_o), 64'(expReq));
      checkOutput("rnd_rvalid", 64'(rvalid_o), 64'(expRvalid));
      if (mRspValid) checkOutput("rnd_rdata", rdata_o, memData(mRspAddr));
      if (req_i == '0) checkOutput("rnd_idle_amo", 64'(bank_amo_o), 64'd0);
      if (expReq) begin
        checkOutput("rnd_add", 64'(bank_add_o), 64'(add_i[sel]));
        checkOutput("rnd_amo", 64'(bank_amo_o), 64'(amo_i[sel]));
        checkOutput("rnd_wen", 64'(bank_wen_o), 64'(wen_i[sel]));
        checkOutput("rnd_wdata", bank_wdata_o, wdata_i[sel]);
        checkOutput("rnd_be", 64'(bank_be_o), 64'(be_i[sel]));
      end
      shimCapture();
      hs = expReq && bank_gnt_i;
      if (hs) begin
        mPtr      = (sel + 1) % N;
        mRspValid = 1;
        mRspId    = sel;
        mRspAddr  = add_i[sel];
        mBusy     = (amo_i[sel] != 4'd0);
      end else begin
        mRspValid = 0;
        mBusy     = 0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
